// File: rtl/ts_pkt_buffer_writer_pkg.sv
// ---------------------------------------------------------------------------
// Package: ts_pkt_buffer_writer_pkg
// Purpose: shared widths, packet type codes and the writer FSM encoding for
//          the TS packet buffer writer and its flow table.
// Ports  : none (package)
// ---------------------------------------------------------------------------
package ts_pkt_buffer_writer_pkg;

    localparam int BUFID_W_DEF     = 9;
    localparam int WORD_ADDR_W_DEF = 7;
    localparam int BYTE_LANES      = 16;
    localparam int CTRL_W          = 19;
    localparam int FLOW_W          = 5;
    localparam int FLOWS           = 32;

    // Packet type codes carried in ctrl[18:16]
    localparam logic [2:0] TYPE_TS0  = 3'b000;
    localparam logic [2:0] TYPE_TS1  = 3'b001;
    localparam logic [2:0] TYPE_TS2  = 3'b010;
    localparam logic [2:0] TYPE_NMAC = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WRITE   = 2'd1,
        ST_DISCARD = 2'd2
    } wr_state_e;

    // TS packets are parked in the flow table instead of being forwarded
    function automatic logic is_ts_type(input logic [2:0] pkt_type);
        return (pkt_type == TYPE_TS0) || (pkt_type == TYPE_TS1) ||
               (pkt_type == TYPE_TS2);
    endfunction

endpackage

// File: rtl/ts_flow_table.sv
// ---------------------------------------------------------------------------
// Module : ts_flow_table
// Purpose: 32-entry per-flow table of parked TS packet BUFIDs plus the
//          occupancy vector. Arbitrates a commit and an inject that land in
//          the same cycle: the inject sees the old entry, the commit's set wins.
// Ports  : i_clk, i_rst_n      clock, async active-low reset
//          i_commit           write iv_commit_bufid to flow iv_commit_flow
//          i_inject           request the BUFID parked at iv_inject_flow
//          ov_ts_cnt          occupancy vector, bit n = flow n occupied
//          ov_inject_bufid    BUFID returned with o_inject_valid
//          o_inject_valid     1-cycle pulse, request hit an occupied flow
//          o_inject_miss      1-cycle pulse, request hit an empty flow
// ---------------------------------------------------------------------------
module ts_flow_table
    import ts_pkt_buffer_writer_pkg::*;
#(
    parameter int BUFID_W = BUFID_W_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_commit,
    input  logic [4:0]          iv_commit_flow,
    input  logic [BUFID_W-1:0]  iv_commit_bufid,
    input  logic                i_inject,
    input  logic [4:0]          iv_inject_flow,
    output logic [31:0]         ov_ts_cnt,
    output logic [BUFID_W-1:0]  ov_inject_bufid,
    output logic                o_inject_valid,
    output logic                o_inject_miss
);

    logic [BUFID_W-1:0] r_table_r [FLOWS];
    logic [31:0]        r_cnt_r;
    logic [31:0]        w_cnt_nxt_s;
    logic               w_hit_s;
    logic [BUFID_W-1:0] r_inj_bufid_r;
    logic               r_inj_valid_r;
    logic               r_inj_miss_r;

    assign w_hit_s = i_inject & r_cnt_r[iv_inject_flow];

    // Next occupancy: inject clears first so a same-cycle commit set wins
    always_comb begin
        w_cnt_nxt_s = r_cnt_r;
        if (w_hit_s) begin
            w_cnt_nxt_s[iv_inject_flow] = 1'b0;
        end else begin
            w_cnt_nxt_s = w_cnt_nxt_s;
        end
        if (i_commit) begin
            w_cnt_nxt_s[iv_commit_flow] = 1'b1;
        end else begin
            w_cnt_nxt_s = w_cnt_nxt_s;
        end
    end

    // Table, occupancy and inject response registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt_r       <= 32'h0000_0000;
            r_inj_bufid_r <= {BUFID_W{1'b0}};
            r_inj_valid_r <= 1'b0;
            r_inj_miss_r  <= 1'b0;
            for (int i = 32'sd0; i < FLOWS; i = i + 32'sd1) begin
                r_table_r[i] <= {BUFID_W{1'b0}};
            end
        end else begin
            r_cnt_r       <= w_cnt_nxt_s;
            r_inj_valid_r <= w_hit_s;
            r_inj_miss_r  <= i_inject & ~r_cnt_r[iv_inject_flow];
            if (w_hit_s) begin
                r_inj_bufid_r <= r_table_r[iv_inject_flow];
            end
            if (i_commit) begin
                r_table_r[iv_commit_flow] <= iv_commit_bufid;
            end
        end
    end

    assign ov_ts_cnt       = r_cnt_r;
    assign ov_inject_bufid = r_inj_bufid_r;
    assign o_inject_valid  = r_inj_valid_r;
    assign o_inject_miss   = r_inj_miss_r;

endmodule

// File: rtl/ts_pkt_buffer_writer.sv
// ---------------------------------------------------------------------------
// Module : ts_pkt_buffer_writer
// Purpose: packs the monitor's 9-bit byte stream into 128-bit buffer words,
//          allocates one BUFID per packet, parks TS packets in the per-flow
//          table and emits descriptors for all other packets.
// Ports  : i_clk/i_rst_n                clock, async active-low reset
//          iv_data/i_data_wr            byte stream, [8] marks head and tail
//          iv_ctrl_data                 type/flow, sampled with the head byte
//          iv_bufid/i_bufid_empty/o_bufid_rd  free-BUFID FIFO (show-ahead)
//          ov_wdata/ov_waddr/o_wr       buffer write port
//          ov_ts_cnt                    per-flow occupancy to the monitor
//          i_ts_inject/iv_ts_inject_flow, ov_ts_inject_bufid,
//          o_ts_inject_valid/o_ts_inject_miss  scheduler inject interface
//          ov_desc/o_desc_wr            forwarding descriptor {ctrl, bufid}
//          o_nobuf_drop_pulse/o_truncate_pulse  drop events
// ---------------------------------------------------------------------------
module ts_pkt_buffer_writer
    import ts_pkt_buffer_writer_pkg::*;
#(
    parameter int BUFID_W     = BUFID_W_DEF,
    parameter int WORD_ADDR_W = WORD_ADDR_W_DEF
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [8:0]                   iv_data,
    input  logic                         i_data_wr,
    input  logic [18:0]                  iv_ctrl_data,
    input  logic [BUFID_W-1:0]           iv_bufid,
    input  logic                         i_bufid_empty,
    output logic                         o_bufid_rd,
    output logic [127:0]                 ov_wdata,
    output logic [BUFID_W+WORD_ADDR_W-1:0] ov_waddr,
    output logic                         o_wr,
    output logic [31:0]                  ov_ts_cnt,
    input  logic                         i_ts_inject,
    input  logic [4:0]                   iv_ts_inject_flow,
    output logic [BUFID_W-1:0]           ov_ts_inject_bufid,
    output logic                         o_ts_inject_valid,
    output logic                         o_ts_inject_miss,
    output logic [19+BUFID_W-1:0]        ov_desc,
    output logic                         o_desc_wr,
    output logic                         o_nobuf_drop_pulse,
    output logic                         o_truncate_pulse
);

    wr_state_e                        r_state_r, w_state_nxt_s;
    logic [BUFID_W-1:0]               r_bufid_r, w_bufid_nxt_s;
    logic [18:0]                      r_ctrl_r, w_ctrl_nxt_s;
    logic [127:0]                     r_lanes_r, w_lanes_nxt_s;
    logic [3:0]                       r_lane_r, w_lane_nxt_s;
    logic [WORD_ADDR_W-1:0]           r_off_r, w_off_nxt_s;
    logic                             r_full_r, w_full_nxt_s;
    logic                             r_trunc_r, w_trunc_nxt_s;
    logic                             r_bufid_rd_r, w_bufid_rd_nxt_s;
    logic [127:0]                     r_wdata_r, w_wdata_nxt_s;
    logic [BUFID_W+WORD_ADDR_W-1:0]   r_waddr_r, w_waddr_nxt_s;
    logic                             r_wr_r, w_wr_nxt_s;
    logic [19+BUFID_W-1:0]            r_desc_r, w_desc_nxt_s;
    logic                             r_desc_wr_r, w_desc_wr_nxt_s;
    logic                             r_nobuf_r, w_nobuf_nxt_s;
    logic                             r_trunc_pulse_r, w_trunc_pulse_nxt_s;
    logic                             w_commit_s;
    logic                             w_mark_s;
    logic [6:0]                       w_hi_s;
    logic [127:0]                     w_word_s;

    assign w_mark_s = i_data_wr & iv_data[8];
    // Lane k occupies bits [127-8k -: 8], so the first byte lands in [127:120]
    assign w_hi_s   = 7'd127 - {r_lane_r, 3'b000};

    // Current word with the incoming byte inserted at the current lane
    always_comb begin
        w_word_s = r_lanes_r;
        w_word_s[w_hi_s -: 8] = iv_data[7:0];
    end

    // FSM next state, packer and output strobes
    always_comb begin
        w_state_nxt_s       = r_state_r;
        w_bufid_nxt_s       = r_bufid_r;
        w_ctrl_nxt_s        = r_ctrl_r;
        w_lanes_nxt_s       = r_lanes_r;
        w_lane_nxt_s        = r_lane_r;
        w_off_nxt_s         = r_off_r;
        w_full_nxt_s        = r_full_r;
        w_trunc_nxt_s       = r_trunc_r;
        w_bufid_rd_nxt_s    = 1'b0;
        w_wdata_nxt_s       = r_wdata_r;
        w_waddr_nxt_s       = r_waddr_r;
        w_wr_nxt_s          = 1'b0;
        w_desc_nxt_s        = r_desc_r;
        w_desc_wr_nxt_s     = 1'b0;
        w_nobuf_nxt_s       = 1'b0;
        w_trunc_pulse_nxt_s = 1'b0;
        w_commit_s          = 1'b0;
        case (r_state_r)
            ST_IDLE: begin
                if (w_mark_s && !i_bufid_empty) begin
                    w_bufid_rd_nxt_s = 1'b1;
                    w_bufid_nxt_s    = iv_bufid;
                    w_ctrl_nxt_s     = iv_ctrl_data;
                    w_lanes_nxt_s    = {iv_data[7:0], 120'h0};
                    w_lane_nxt_s     = 4'd1;
                    w_off_nxt_s      = {WORD_ADDR_W{1'b0}};
                    w_full_nxt_s     = 1'b0;
                    w_trunc_nxt_s    = 1'b0;
                    w_state_nxt_s    = ST_WRITE;
                end else if (w_mark_s) begin
                    w_nobuf_nxt_s    = 1'b1;
                    w_state_nxt_s    = ST_DISCARD;
                end else begin
                    w_state_nxt_s    = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (i_data_wr) begin
                    if (r_full_r) begin
                        // Buffer exhausted: drop the byte, flag only the first drop
                        w_trunc_pulse_nxt_s = ~r_trunc_r;
                        w_trunc_nxt_s       = 1'b1;
                    end else if ((r_lane_r == 4'd15) || iv_data[8]) begin
                        w_wr_nxt_s    = 1'b1;
                        w_wdata_nxt_s = w_word_s;
                        w_waddr_nxt_s = {r_bufid_r, r_off_r};
                        w_lanes_nxt_s = 128'h0;
                        w_lane_nxt_s  = 4'd0;
                        w_off_nxt_s   = r_off_r + {{(WORD_ADDR_W-1){1'b0}}, 1'b1};
                        w_full_nxt_s  = (r_off_r == {WORD_ADDR_W{1'b1}});
                    end else begin
                        w_lanes_nxt_s = w_word_s;
                        w_lane_nxt_s  = r_lane_r + 4'd1;
                    end
                    // Commit in the tail cycle so it becomes visible with the last write
                    if (iv_data[8]) begin
                        w_state_nxt_s = ST_IDLE;
                        if (is_ts_type(r_ctrl_r[18:16])) begin
                            w_commit_s = 1'b1;
                        end else begin
                            w_desc_wr_nxt_s = 1'b1;
                            w_desc_nxt_s    = {r_ctrl_r, r_bufid_r};
                        end
                    end else begin
                        w_state_nxt_s = ST_WRITE;
                    end
                end else begin
                    w_state_nxt_s = ST_WRITE;
                end
            end
            ST_DISCARD: begin
                if (w_mark_s) begin
                    w_state_nxt_s = ST_IDLE;
                end else begin
                    w_state_nxt_s = ST_DISCARD;
                end
            end
            default: begin
                w_state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, packer context and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state_r       <= ST_IDLE;
            r_bufid_r       <= {BUFID_W{1'b0}};
            r_ctrl_r        <= 19'h0;
            r_lanes_r       <= 128'h0;
            r_lane_r        <= 4'd0;
            r_off_r         <= {WORD_ADDR_W{1'b0}};
            r_full_r        <= 1'b0;
            r_trunc_r       <= 1'b0;
            r_bufid_rd_r    <= 1'b0;
            r_wdata_r       <= 128'h0;
            r_waddr_r       <= {(BUFID_W+WORD_ADDR_W){1'b0}};
            r_wr_r          <= 1'b0;
            r_desc_r        <= {(19+BUFID_W){1'b0}};
            r_desc_wr_r     <= 1'b0;
            r_nobuf_r       <= 1'b0;
            r_trunc_pulse_r <= 1'b0;
        end else begin
            r_state_r       <= w_state_nxt_s;
            r_bufid_r       <= w_bufid_nxt_s;
            r_ctrl_r        <= w_ctrl_nxt_s;
            r_lanes_r       <= w_lanes_nxt_s;
            r_lane_r        <= w_lane_nxt_s;
            r_off_r         <= w_off_nxt_s;
            r_full_r        <= w_full_nxt_s;
            r_trunc_r       <= w_trunc_nxt_s;
            r_bufid_rd_r    <= w_bufid_rd_nxt_s;
            r_wdata_r       <= w_wdata_nxt_s;
            r_waddr_r       <= w_waddr_nxt_s;
            r_wr_r          <= w_wr_nxt_s;
            r_desc_r        <= w_desc_nxt_s;
            r_desc_wr_r     <= w_desc_wr_nxt_s;
            r_nobuf_r       <= w_nobuf_nxt_s;
            r_trunc_pulse_r <= w_trunc_pulse_nxt_s;
        end
    end

    ts_flow_table #(
        .BUFID_W (BUFID_W)
    ) u_flow_table (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_commit        (w_commit_s),
        .iv_commit_flow  (r_ctrl_r[15:11]),
        .iv_commit_bufid (r_bufid_r),
        .i_inject        (i_ts_inject),
        .iv_inject_flow  (iv_ts_inject_flow),
        .ov_ts_cnt       (ov_ts_cnt),
        .ov_inject_bufid (ov_ts_inject_bufid),
        .o_inject_valid  (o_ts_inject_valid),
        .o_inject_miss   (o_ts_inject_miss)
    );

    assign o_bufid_rd         = r_bufid_rd_r;
    assign ov_wdata           = r_wdata_r;
    assign ov_waddr           = r_waddr_r;
    assign o_wr               = r_wr_r;
    assign ov_desc            = r_desc_r;
    assign o_desc_wr          = r_desc_wr_r;
    assign o_nobuf_drop_pulse = r_nobuf_r;
    assign o_truncate_pulse   = r_trunc_pulse_r;

endmodule

// File: tb/tb_ts_pkt_buffer_writer.sv
// ---------------------------------------------------------------------------
// Testbench for ts_pkt_buffer_writer: directed packets with hand-computed
// expectations; a negedge monitor records write, descriptor and pulse events.
// ---------------------------------------------------------------------------
module tb_ts_pkt_buffer_writer;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic [8:0]    iv_data;
    logic          i_data_wr;
    logic [18:0]   iv_ctrl_data;
    logic [8:0]    iv_bufid;
    logic          i_bufid_empty;
    logic          o_bufid_rd;
    logic [127:0]  ov_wdata;
    logic [15:0]   ov_waddr;
    logic          o_wr;
    logic [31:0]   ov_ts_cnt;
    logic          i_ts_inject;
    logic [4:0]    iv_ts_inject_flow;
    logic [8:0]    ov_ts_inject_bufid;
    logic          o_ts_inject_valid;
    logic          o_ts_inject_miss;
    logic [27:0]   ov_desc;
    logic          o_desc_wr;
    logic          o_nobuf_drop_pulse;
    logic          o_truncate_pulse;

    int checks = 0;
    int failures = 0;

    // monitor records
    logic [127:0] wd_q[$];
    logic [15:0]  wa_q[$];
    int           desc_cnt, rd_cnt, nobuf_cnt, trunc_cnt, inj_cnt, miss_cnt;
    int           desc_wrs;
    logic         desc_with_wr;
    logic [27:0]  last_desc;
    logic [8:0]   last_inj;

    always #5 i_clk = ~i_clk;

    ts_pkt_buffer_writer dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .iv_data(iv_data), .i_data_wr(i_data_wr),
        .iv_ctrl_data(iv_ctrl_data), .iv_bufid(iv_bufid), .i_bufid_empty(i_bufid_empty),
        .o_bufid_rd(o_bufid_rd), .ov_wdata(ov_wdata), .ov_waddr(ov_waddr), .o_wr(o_wr),
        .ov_ts_cnt(ov_ts_cnt), .i_ts_inject(i_ts_inject), .iv_ts_inject_flow(iv_ts_inject_flow),
        .ov_ts_inject_bufid(ov_ts_inject_bufid), .o_ts_inject_valid(o_ts_inject_valid),
        .o_ts_inject_miss(o_ts_inject_miss), .ov_desc(ov_desc), .o_desc_wr(o_desc_wr),
        .o_nobuf_drop_pulse(o_nobuf_drop_pulse), .o_truncate_pulse(o_truncate_pulse)
    );

    always @(negedge i_clk) begin
        if (o_wr) begin
            wd_q.push_back(ov_wdata);
            wa_q.push_back(ov_waddr);
        end
        if (o_desc_wr) begin
            desc_cnt++;
            last_desc    = ov_desc;
            desc_wrs     = wd_q.size();
            desc_with_wr = o_wr;
        end
        if (o_bufid_rd)         rd_cnt++;
        if (o_nobuf_drop_pulse) nobuf_cnt++;
        if (o_truncate_pulse)   trunc_cnt++;
        if (o_ts_inject_valid) begin
            inj_cnt++;
            last_inj = ov_ts_inject_bufid;
        end
        if (o_ts_inject_miss)   miss_cnt++;
    end

    function automatic logic [7:0] pbyte(input int seed, input int k);
        return 8'((k * 7 + seed) & 255);
    endfunction

    function automatic logic [127:0] exp_word(input int seed, input int w, input int n);
        logic [127:0] r;
        r = 128'h0;
        for (int l = 0; l < 16; l++) begin
            if (16 * w + l < n) r[127 - 8 * l -: 8] = pbyte(seed, 16 * w + l);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_mon();
        wd_q.delete();
        wa_q.delete();
        desc_cnt = 0; rd_cnt = 0; nobuf_cnt = 0; trunc_cnt = 0;
        inj_cnt = 0; miss_cnt = 0; desc_wrs = -1; desc_with_wr = 1'b0;
        last_desc = 28'h0; last_inj = 9'h0;
    endtask

    // ctrl is presented only with the head byte; later bytes carry junk ctrl
    task automatic send_pkt(input int len, input logic [18:0] ctrl, input int seed,
                            input bit gaps, input bit inj, input logic [4:0] inj_flow,
                            input logic [8:0] next_bufid);
        for (int k = 0; k < len; k++) begin
            if (gaps && (k % 5 == 3)) begin
                i_data_wr = 1'b0;
                tick();
            end
            iv_data      = {(k == 0) || (k == len - 1), pbyte(seed, k)};
            i_data_wr    = 1'b1;
            iv_ctrl_data = (k == 0) ? ctrl : 19'h7FFFF;
            i_ts_inject  = inj && (k == len - 1);
            iv_ts_inject_flow = inj_flow;
            tick();
            if (k == 0) iv_bufid = next_bufid;
        end
        i_data_wr   = 1'b0;
        i_ts_inject = 1'b0;
        iv_data     = 9'h0;
    endtask

    task automatic inject(input logic [4:0] flow);
        i_ts_inject = 1'b1;
        iv_ts_inject_flow = flow;
        tick();
        i_ts_inject = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        iv_data = 9'h0; i_data_wr = 1'b0; iv_ctrl_data = 19'h0; iv_bufid = 9'h0;
        i_bufid_empty = 1'b0; i_ts_inject = 1'b0; iv_ts_inject_flow = 5'd0;
        repeat (3) tick();
        i_rst_n = 1'b1;
        tick();
        checks++; if ({o_wr, o_bufid_rd, o_desc_wr, o_ts_inject_valid, o_ts_inject_miss,
                       o_nobuf_drop_pulse, o_truncate_pulse} !== 7'h0) begin
            failures++; $display("FAIL reset_strobes got=%b exp=0", {o_wr, o_bufid_rd, o_desc_wr});
        end
        checks++; if (ov_ts_cnt !== 32'h0) begin
            failures++; $display("FAIL reset_ts_cnt got=%h exp=0", ov_ts_cnt);
        end
        checks++; if ({ov_wdata, ov_waddr, ov_desc, ov_ts_inject_bufid} !== 181'h0) begin
            failures++; $display("FAIL reset_data got=%h/%h/%h exp=0", ov_wdata, ov_waddr, ov_desc);
        end
    endtask

    task automatic test_nonts_64();
        logic [18:0] ctrl;
        ctrl = {3'b101, 5'd2, 11'h2A5};
        clear_mon();
        iv_bufid = 9'h012;
        send_pkt(64, ctrl, 3, 1'b1, 1'b0, 5'd0, 9'h013);
        repeat (3) tick();
        checks++; if (wa_q.size() != 4) begin
            failures++; $display("FAIL nonts_wr_count got=%0d exp=4", wa_q.size());
        end else begin
            for (int w = 0; w < 4; w++) begin
                checks++; if (wa_q[w] !== {9'h012, 7'(w)} || wd_q[w] !== exp_word(3, w, 64)) begin
                    failures++; $display("FAIL nonts_word%0d got=%h:%h exp=%h:%h", w,
                                         wa_q[w], wd_q[w], {9'h012, 7'(w)}, exp_word(3, w, 64));
                end
            end
        end
        checks++; if (desc_cnt != 1 || last_desc !== {ctrl, 9'h012}) begin
            failures++; $display("FAIL nonts_desc got=%0d:%h exp=1:%h", desc_cnt, last_desc, {ctrl, 9'h012});
        end
        checks++; if (desc_wrs != 4 || desc_with_wr !== 1'b1) begin
            failures++; $display("FAIL nonts_desc_align got=%0d,%b exp=4,1", desc_wrs, desc_with_wr);
        end
        checks++; if (rd_cnt != 1) begin
            failures++; $display("FAIL nonts_bufid_rd got=%0d exp=1", rd_cnt);
        end
    endtask

    task automatic test_ts_20();
        logic [127:0] w1;
        clear_mon();
        iv_bufid = 9'h033;
        send_pkt(20, {3'b000, 5'd5, 11'h0}, 11, 1'b0, 1'b0, 5'd0, 9'h034);
        repeat (2) tick();
        w1 = {pbyte(11, 16), pbyte(11, 17), pbyte(11, 18), pbyte(11, 19), 96'h0};
        checks++; if (wa_q.size() != 2 || wd_q[1] !== w1 || wa_q[1] !== {9'h033, 7'd1}) begin
            failures++; $display("FAIL ts_partial got=%0d words last=%h exp=2 words last=%h",
                                 wa_q.size(), (wd_q.size() > 1) ? wd_q[1] : 128'h0, w1);
        end
        checks++; if (ov_ts_cnt !== 32'h20 || desc_cnt != 0) begin
            failures++; $display("FAIL ts_commit got=%h desc=%0d exp=00000020 desc=0", ov_ts_cnt, desc_cnt);
        end
        inject(5'd5);
        checks++; if (o_ts_inject_valid !== 1'b1 || ov_ts_inject_bufid !== 9'h033 || ov_ts_cnt !== 32'h0) begin
            failures++; $display("FAIL ts_inject got=%b/%h/%h exp=1/033/0", o_ts_inject_valid,
                                 ov_ts_inject_bufid, ov_ts_cnt);
        end
        tick();
        checks++; if (o_ts_inject_valid !== 1'b0) begin
            failures++; $display("FAIL ts_inject_pulse got=%b exp=0", o_ts_inject_valid);
        end
    endtask

    task automatic test_nobuf();
        clear_mon();
        i_bufid_empty = 1'b1;
        send_pkt(30, {3'b101, 5'd1, 11'h0}, 5, 1'b0, 1'b0, 5'd0, 9'h034);
        i_bufid_empty = 1'b0;
        repeat (2) tick();
        checks++; if (nobuf_cnt != 1 || wa_q.size() != 0 || rd_cnt != 0 || desc_cnt != 0) begin
            failures++; $display("FAIL nobuf got=drop%0d wr%0d rd%0d desc%0d exp=1,0,0,0",
                                 nobuf_cnt, wa_q.size(), rd_cnt, desc_cnt);
        end
    endtask

    task automatic test_truncate();
        logic [18:0] ctrl;
        ctrl = {3'b101, 5'd9, 11'h011};
        clear_mon();
        iv_bufid = 9'h1A0;
        send_pkt(2100, ctrl, 1, 1'b0, 1'b0, 5'd0, 9'h1A1);
        repeat (2) tick();
        checks++; if (wa_q.size() != 128) begin
            failures++; $display("FAIL trunc_wr_count got=%0d exp=128", wa_q.size());
        end else begin
            checks++; if (wa_q[127] !== {9'h1A0, 7'd127} || wd_q[127] !== exp_word(1, 127, 2100)) begin
                failures++; $display("FAIL trunc_last got=%h:%h exp=%h:%h", wa_q[127], wd_q[127],
                                     {9'h1A0, 7'd127}, exp_word(1, 127, 2100));
            end
        end
        checks++; if (trunc_cnt != 1) begin
            failures++; $display("FAIL trunc_pulse got=%0d exp=1", trunc_cnt);
        end
        checks++; if (desc_cnt != 1 || last_desc !== {ctrl, 9'h1A0}) begin
            failures++; $display("FAIL trunc_desc got=%0d:%h exp=1:%h", desc_cnt, last_desc, {ctrl, 9'h1A0});
        end
    endtask

    task automatic test_same_cycle();
        clear_mon();
        iv_bufid = 9'h007;
        send_pkt(17, {3'b001, 5'd3, 11'h0}, 2, 1'b0, 1'b0, 5'd0, 9'h009);
        tick();
        send_pkt(17, {3'b010, 5'd3, 11'h0}, 4, 1'b0, 1'b1, 5'd3, 9'h00A);
        tick();
        checks++; if (inj_cnt != 1 || last_inj !== 9'h007) begin
            failures++; $display("FAIL same_cycle_inject got=%0d:%h exp=1:007", inj_cnt, last_inj);
        end
        checks++; if (ov_ts_cnt !== 32'h8) begin
            failures++; $display("FAIL same_cycle_cnt got=%h exp=00000008", ov_ts_cnt);
        end
        inject(5'd3);
        checks++; if (o_ts_inject_valid !== 1'b1 || ov_ts_inject_bufid !== 9'h009 || ov_ts_cnt !== 32'h0) begin
            failures++; $display("FAIL same_cycle_new got=%b/%h/%h exp=1/009/0", o_ts_inject_valid,
                                 ov_ts_inject_bufid, ov_ts_cnt);
        end
        inject(5'd4);
        checks++; if (o_ts_inject_miss !== 1'b1 || o_ts_inject_valid !== 1'b0 || ov_ts_cnt !== 32'h0) begin
            failures++; $display("FAIL inject_miss got=%b/%b/%h exp=1/0/0", o_ts_inject_miss,
                                 o_ts_inject_valid, ov_ts_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [18:0] ca, cb;
        ca = {3'b101, 5'd0, 11'h0AA};
        cb = {3'b101, 5'd1, 11'h055};
        clear_mon();
        iv_bufid = 9'h0A0;
        send_pkt(18, ca, 20, 1'b0, 1'b0, 5'd0, 9'h0B0);
        send_pkt(16, cb, 40, 1'b0, 1'b0, 5'd0, 9'h0C0);
        repeat (2) tick();
        checks++; if (wa_q.size() != 3) begin
            failures++; $display("FAIL b2b_wr_count got=%0d exp=3", wa_q.size());
        end else begin
            checks++; if (wa_q[1] !== {9'h0A0, 7'd1} || wd_q[1] !== {pbyte(20, 16), pbyte(20, 17), 112'h0}) begin
                failures++; $display("FAIL b2b_partial got=%h:%h exp=%h:%h", wa_q[1], wd_q[1],
                                     {9'h0A0, 7'd1}, {pbyte(20, 16), pbyte(20, 17), 112'h0});
            end
            checks++; if (wa_q[2] !== {9'h0B0, 7'd0} || wd_q[2] !== exp_word(40, 0, 16)) begin
                failures++; $display("FAIL b2b_second got=%h:%h exp=%h:%h", wa_q[2], wd_q[2],
                                     {9'h0B0, 7'd0}, exp_word(40, 0, 16));
            end
        end
        checks++; if (desc_cnt != 2 || last_desc !== {cb, 9'h0B0} || rd_cnt != 2) begin
            failures++; $display("FAIL b2b_desc got=%0d:%h rd=%0d exp=2:%h rd=2", desc_cnt, last_desc,
                                 rd_cnt, {cb, 9'h0B0});
        end
    endtask

    task automatic test_reset_mid();
        iv_bufid = 9'h077;
        send_pkt(16, {3'b000, 5'd7, 11'h0}, 8, 1'b0, 1'b0, 5'd0, 9'h0C1);
        tick();
        iv_ctrl_data = {3'b101, 5'd0, 11'h0};
        for (int k = 0; k < 16; k++) begin
            iv_data   = {(k == 0), pbyte(9, k)};
            i_data_wr = 1'b1;
            tick();
        end
        checks++; if (o_wr !== 1'b1 || ov_ts_cnt !== 32'h80) begin
            failures++; $display("FAIL pre_reset got=%b/%h exp=1/00000080", o_wr, ov_ts_cnt);
        end
        #2 i_rst_n = 1'b0;
        #1;
        checks++; if (o_wr !== 1'b0 || ov_wdata !== 128'h0 || ov_waddr !== 16'h0 || ov_ts_cnt !== 32'h0) begin
            failures++; $display("FAIL mid_reset got=%b/%h/%h/%h exp=0", o_wr, ov_wdata, ov_waddr, ov_ts_cnt);
        end
        i_data_wr = 1'b0;
        tick();
        i_rst_n = 1'b1;
        tick();
        clear_mon();
        iv_bufid = 9'h055;
        send_pkt(16, {3'b101, 5'd2, 11'h0}, 30, 1'b0, 1'b0, 5'd0, 9'h056);
        repeat (2) tick();
        checks++; if (wa_q.size() != 1 || wa_q[0] !== {9'h055, 7'd0} || wd_q[0] !== exp_word(30, 0, 16)
                      || desc_cnt != 1) begin
            failures++; $display("FAIL post_reset_pkt got=%0d writes desc=%0d exp=1 write at 055/0 desc=1",
                                 wa_q.size(), desc_cnt);
        end
        inject(5'd7);
        checks++; if (o_ts_inject_miss !== 1'b1) begin
            failures++; $display("FAIL post_reset_table got=%b exp=1", o_ts_inject_miss);
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_nonts_64();
        test_ts_20();
        test_nobuf();
        test_truncate();
        test_same_cycle();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
